// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receiver.
package i2c_pkg;

  localparam int BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] BYTE_BITS = 4'd8;
  localparam logic [BIT_CNT_W-1:0] BYTE_LAST = 4'd7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_SKIP
  } state_e;

endpackage

// File: rtl/i2c_target_rx_line_sync.sv
// SCL/SDA synchronizer with single-cycle edge, START and STOP detection.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;

  // Idle bus is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_q      <= scl_s;
      sda_q      <= sda;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda       = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target: address match, register pointer, write strobes and read shift-out.
//  state        | meaning
//  ST_IDLE      | bus free or not addressed
//  ST_ADDR      | shifting in {addr, rw}
//  ST_ADDR_ACK  | acknowledging our address
//  ST_REG       | shifting in register pointer
//  ST_REG_ACK   | acknowledging pointer byte
//  ST_WDATA     | shifting in write data
//  ST_WDATA_ACK | acknowledging write data, pointer bumps at end
//  ST_RDATA     | shifting out read data
//  ST_RDATA_ACK | sampling master ACK/NACK
//  ST_SKIP      | ignoring bus until START/STOP
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda       (sda)
  );

  state_e               state_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [6:0]           shift_q;
  logic [6:0]           tx_q;
  logic                 rw_q;
  logic                 sda_oe_q, wr_valid_q, rd_req_q, busy_q;
  logic [7:0]           reg_addr_q, wr_data_q;
  logic [7:0]           rx_byte_d;

  assign rx_byte_d = {shift_q, sda};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      reg_addr_q <= 8'h00;
      wr_data_q  <= 8'h00;
    end else begin
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      if (start_det) begin
        state_q   <= ST_ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
      end else if (stop_det) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR, ST_REG, ST_WDATA: begin
            if (scl_rise) begin
              shift_q   <= rx_byte_d[6:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == BYTE_LAST) begin
                case (state_q)
                  ST_ADDR: begin
                    if (rx_byte_d[7:1] == DEV_ADDR) begin
                      state_q <= ST_ADDR_ACK;
                      busy_q  <= 1'b1;
                      rw_q    <= rx_byte_d[0];
                    end else begin
                      state_q <= ST_SKIP;
                      busy_q  <= 1'b0;
                    end
                  end
                  ST_REG: begin
                    reg_addr_q <= rx_byte_d;
                    state_q    <= ST_REG_ACK;
                  end
                  default: begin
                    wr_data_q  <= rx_byte_d;
                    wr_valid_q <= 1'b1;
                    state_q    <= ST_WDATA_ACK;
                  end
                endcase
              end
            end
          end
          // bit_cnt_q == 8 marks "ACK not yet driven"; 0 marks "ACK on the bus".
          ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= '0;
              if (bit_cnt_q == BYTE_BITS) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                case (state_q)
                  ST_ADDR_ACK: begin
                    if (rw_q) begin
                      tx_q     <= rd_data[6:0];
                      sda_oe_q <= ~rd_data[7];
                      state_q  <= ST_RDATA;
                    end else begin
                      state_q <= ST_REG;
                    end
                  end
                  ST_REG_ACK: state_q <= ST_WDATA;
                  default: begin
                    reg_addr_q <= reg_addr_q + 8'd1;
                    state_q    <= ST_WDATA;
                  end
                endcase
              end
            end else if (scl_rise && state_q == ST_ADDR_ACK && rw_q && bit_cnt_q == '0) begin
              rd_req_q <= 1'b1;
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == BYTE_BITS) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= ST_RDATA_ACK;
              end else begin
                sda_oe_q <= ~tx_q[6];
                tx_q     <= {tx_q[5:0], 1'b0};
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda == I2C_ACK) begin
                reg_addr_q <= reg_addr_q + 8'd1;
                rd_req_q   <= 1'b1;
              end else begin
                state_q <= ST_SKIP;
              end
            end else if (scl_fall) begin
              tx_q      <= rd_data[6:0];
              sda_oe_q  <= ~rd_data[7];
              bit_cnt_q <= '0;
              state_q   <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign reg_addr = reg_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_valid = wr_valid_q;
  assign rd_req   = rd_req_q;
  assign busy     = busy_q;

endmodule
